// File: rtl/dice_roll_sequencer.sv
// Turns a debounced roll request into one validated dice face: settle for a few frames, then
// wait for STABLE_FRAMES identical valid classifications, or abort on timeout / init_done loss.
module dice_roll_sequencer #(
  parameter int SETTLE_FRAMES  = 2,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       roll_req,
  input  logic       cam_vsync,
  input  logic [2:0] dice_raw,
  output logic       busy,
  output logic       dice_en,
  output logic [2:0] dice_value,
  output logic       dice_err
);

  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int RW = $clog2(STABLE_FRAMES + 1);
  localparam int FW = $clog2(TIMEOUT_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DONE, ERR} state_t;

  state_t         state_q;
  logic           sync1_q, sync2_q, vs_prev_q;
  logic [SW-1:0]  settle_q, settle_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [RW-1:0]  run_q, run_d;
  logic [2:0]     cand_q;
  logic [2:0]     value_q;
  logic           busy_q, en_q, err_q;
  logic           tick, raw_valid;

  // Classifier output is only trustworthy once the frame has ended (falling VSYNC).
  assign tick      = vs_prev_q & ~sync2_q;
  assign raw_valid = (dice_raw != 3'd0) && (dice_raw != 3'd7);

  always_comb begin
    settle_d = settle_q + 1'b1;
    frame_d  = frame_q + 1'b1;
    run_d    = '0;
    if (raw_valid && (dice_raw == cand_q))
      run_d = run_q + 1'b1;
    else if (raw_valid)
      run_d = RW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      state_q   <= IDLE;
      settle_q  <= '0;
      frame_q   <= '0;
      run_q     <= '0;
      cand_q    <= 3'd0;
      value_q   <= 3'd0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= cam_vsync;
      sync2_q   <= sync1_q;
      vs_prev_q <= sync2_q;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (roll_req && init_done) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        SETTLE: begin
          if (!init_done) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (tick) begin
            if (settle_d == SW'(SETTLE_FRAMES)) begin
              state_q <= SAMPLE;
              frame_q <= '0;
              run_q   <= '0;
              cand_q  <= 3'd0;
            end else begin
              settle_q <= settle_d;
            end
          end
        end
        SAMPLE: begin
          if (!init_done) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (tick) begin
            frame_q <= frame_d;
            run_q   <= run_d;
            cand_q  <= dice_raw;
            // A completed run wins over a timeout landing on the same frame.
            if (run_d == RW'(STABLE_FRAMES)) begin
              state_q <= DONE;
              value_q <= dice_raw;
              en_q    <= 1'b1;
            end else if (frame_d == FW'(TIMEOUT_FRAMES)) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign dice_en    = en_q;
  assign dice_err   = err_q;
  assign dice_value = value_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Scenario bench for dice_roll_sequencer; a forked monitor scores every result pulse against a queue.
module tb_dice_roll_sequencer;
  localparam int SETTLE = 2;
  localparam int STABLE = 3;
  localparam int TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       reset, init_done, roll_req, cam_vsync;
  logic [2:0] dice_raw;
  logic       busy, dice_en, dice_err;
  logic [2:0] dice_value;

  int checks = 0;
  int errors = 0;
  logic [2:0] last_val;

  typedef struct {
    bit         err;
    logic [2:0] val;
  } exp_t;
  exp_t exp_q[$];

  dice_roll_sequencer #(
    .SETTLE_FRAMES(SETTLE),
    .STABLE_FRAMES(STABLE),
    .TIMEOUT_FRAMES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init_done(init_done),
    .roll_req(roll_req),
    .cam_vsync(cam_vsync),
    .dice_raw(dice_raw),
    .busy(busy),
    .dice_en(dice_en),
    .dice_value(dice_value),
    .dice_err(dice_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input bit err, input logic [2:0] v);
    exp_t e;
    e.err = err;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (dice_en || dice_err)) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL pulse_width: pulse high on consecutive cycles (en=%0b err=%0b)", dice_en, dice_err);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: en=%0b err=%0b value=%0d, none expected", dice_en, dice_err, dice_value);
        end else begin
          e = exp_q.pop_front();
          if ({dice_err, dice_en, dice_value} !== {e.err, !e.err, e.val}) begin
            errors++;
            $display("FAIL scoreboard: got err=%0b en=%0b value=%0d, want err=%0b en=%0b value=%0d",
                     dice_err, dice_en, dice_value, e.err, !e.err, e.val);
          end
        end
      end
      prev = !reset && (dice_en || dice_err);
    end
  endtask

  // One camera frame: raw value presented, VSYNC high then falling; returns just after the tick is consumed.
  task automatic frame(input logic [2:0] v);
    @(negedge clk);
    dice_raw  = v;
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic start_roll(input logic exp_busy, input logic [2:0] settle_v);
    @(negedge clk);
    roll_req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy_on_req: busy=%0b want %0b", busy, exp_busy);
    end
    @(negedge clk);
    roll_req = 1'b0;
    for (int i = 0; i < SETTLE; i++) frame(settle_v);
  endtask

  task automatic sample_frames(input logic [2:0] seq [10], input int n, input bit exp_err,
                               input logic [2:0] exp_val, input string name);
    for (int i = 0; i < n; i++) begin
      frame(seq[i]);
      checks++;
      if (i < n - 1) begin
        if ({dice_en, dice_err, busy} !== 3'b001) begin
          errors++;
          $display("FAIL %s_early: frame %0d en=%0b err=%0b busy=%0b want 0 0 1", name, i, dice_en, dice_err, busy);
        end
      end else if ({dice_en, dice_err, dice_value} !== {!exp_err, exp_err, exp_val}) begin
        errors++;
        $display("FAIL %s_result: en=%0b err=%0b value=%0d want en=%0b err=%0b value=%0d",
                 name, dice_en, dice_err, dice_value, !exp_err, exp_err, exp_val);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, dice_en, dice_err} !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b en=%0b err=%0b want 0 0 0", name, busy, dice_en, dice_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, dice_en, dice_err, dice_value} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b en=%0b err=%0b value=%0d want all 0", busy, dice_en, dice_err, dice_value);
    end
    @(negedge clk);
    reset = 1'b0;
    last_val = 3'd0;
  endtask

  task automatic test_clean_roll();
    logic [2:0] s [10] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    push_exp(1'b0, 3'd4);
    last_val = 3'd4;
    start_roll(1'b1, 3'd4);
    sample_frames(s, STABLE, 1'b0, 3'd4, "clean");
  endtask

  task automatic test_unstable();
    logic [2:0] s [10] = '{4, 4, 5, 5, 5, 0, 0, 0, 0, 0};
    push_exp(1'b0, 3'd5);
    last_val = 3'd5;
    start_roll(1'b1, 3'd1);
    sample_frames(s, 5, 1'b0, 3'd5, "unstable");
  endtask

  task automatic test_invalid();
    logic [2:0] s [10] = '{3, 0, 3, 3, 7, 3, 3, 3, 0, 0};
    push_exp(1'b0, 3'd3);
    last_val = 3'd3;
    start_roll(1'b1, 3'd6);
    sample_frames(s, 8, 1'b0, 3'd3, "invalid");
  endtask

  task automatic test_timeout();
    logic [2:0] s [10] = '{2, 6, 2, 6, 2, 6, 2, 6, 2, 6};
    push_exp(1'b1, last_val);
    start_roll(1'b1, 3'd2);
    sample_frames(s, TIMEOUT, 1'b1, last_val, "timeout");
  endtask

  task automatic test_gating();
    init_done = 1'b0;
    start_roll(1'b0, 3'd4);
    frame(3'd4);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL gating: busy=%0b want 0", busy);
    end
    init_done = 1'b1;
  endtask

  task automatic test_overlap();
    push_exp(1'b0, 3'd6);
    last_val = 3'd6;
    start_roll(1'b1, 3'd6);
    frame(3'd6);
    @(negedge clk);
    roll_req = 1'b1;
    @(negedge clk);
    roll_req = 1'b0;
    frame(3'd6);
    frame(3'd6);
    checks++;
    if ({dice_en, dice_value} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL overlap_result: en=%0b value=%0d want 1 6", dice_en, dice_value);
    end
    for (int i = 0; i < SETTLE + STABLE + 1; i++) frame(3'd1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL overlap_queued: busy=%0b want 0", busy);
    end
  endtask

  task automatic test_init_drop();
    push_exp(1'b1, last_val);
    start_roll(1'b1, 3'd2);
    frame(3'd2);
    @(negedge clk);
    init_done = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({dice_err, dice_en, busy, dice_value} !== {1'b1, 1'b0, 1'b1, last_val}) begin
      errors++;
      $display("FAIL init_drop_err: err=%0b en=%0b busy=%0b value=%0d want 1 0 1 %0d",
               dice_err, dice_en, busy, dice_value, last_val);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, dice_err} !== 2'b00) begin
      errors++;
      $display("FAIL init_drop_idle: busy=%0b err=%0b want 0 0", busy, dice_err);
    end
    @(negedge clk);
    init_done = 1'b1;
  endtask

  task automatic test_reset_mid_roll();
    logic [2:0] s [10] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    start_roll(1'b1, 3'd5);
    frame(3'd5);
    frame(3'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, dice_en, dice_err, dice_value} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%0b en=%0b err=%0b value=%0d want all 0", busy, dice_en, dice_err, dice_value);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_val = 3'd0;
    push_exp(1'b0, 3'd2);
    last_val = 3'd2;
    start_roll(1'b1, 3'd2);
    sample_frames(s, STABLE, 1'b0, 3'd2, "after_reset");
  endtask

  initial begin
    reset     = 1'b1;
    init_done = 1'b1;
    roll_req  = 1'b0;
    cam_vsync = 1'b0;
    dice_raw  = 3'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_clean_roll();
    test_unstable();
    test_invalid();
    test_timeout();
    test_gating();
    test_overlap();
    test_init_drop();
    test_reset_mid_roll();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d expected pulses never seen, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dice_roll_sequencer.md
# dice_roll_sequencer

Sequences one dice read per player request: after a debounced roll request it waits for the camera to settle, then watches per-frame dice classifications until the same face is seen on several consecutive frames. It then publishes one validated result to the game logic. It sits between the button debouncer, the camera-domain dice classifier and the game master FSM, all on the 100 MHz system clock. It replaces direct use of the classifier's free-running value.

## Interface
- SETTLE_FRAMES, 2: frame ticks discarded after a request before sampling starts (≥1).
- STABLE_FRAMES, 3: consecutive identical valid classifications required (≥1).
- TIMEOUT_FRAMES, 30: maximum frame ticks spent in sampling before abort (≥ STABLE_FRAMES).
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- init_done  in  1  camera SCCB configuration complete (clk domain, level).
- roll_req  in  1  single-cycle roll request (debounced button tick).
- cam_vsync  in  1  camera VSYNC, asynchronous to clk.
- dice_raw  in  3  per-frame classifier output. 1–6 is valid; 0 and 7 mean no dice. Stable while cam_vsync is low.
- busy  out  1  high while a roll is in progress.
- dice_en  out  1  single-cycle pulse: dice_value holds a new validated result.
- dice_value  out  3  last validated result, held until the next success.
- dice_err  out  1  single-cycle pulse: roll aborted by timeout or by loss of init_done.

## Operation
- Frame tick:
  - cam_vsync passes through a 2-FF synchronizer, then an edge register.
  - tick = falling edge of the synchronized vsync.
  - dice_raw is sampled only on tick, when the classifier value is stable.
- States: IDLE, SETTLE, SAMPLE, DONE, ERR. busy = (state != IDLE).
- IDLE:
  - roll_req=1 and init_done=1 → SETTLE; settle counter cleared.
  - roll_req with init_done=0 is ignored.
- SETTLE:
  - counts ticks; after SETTLE_FRAMES ticks → SAMPLE.
  - On entry to SAMPLE: frame counter=0, run counter=0, candidate=0.
- SAMPLE, on each tick:
  - frame counter increments.
  - If dice_raw is valid and equals candidate, run counter increments.
  - Else candidate ← dice_raw, and run counter ← 1 if valid, 0 if invalid.
  - If the run counter reaches STABLE_FRAMES → DONE and dice_value ← candidate. Success takes priority over timeout on the same tick.
  - Else if the frame counter reaches TIMEOUT_FRAMES → ERR.
- DONE: dice_en=1 for exactly one cycle → IDLE.
- ERR: dice_err=1 for exactly one cycle → IDLE; dice_value unchanged.
- init_done low while in SETTLE or SAMPLE → ERR on the next clock.
- roll_req while busy (including DONE/ERR cycles) is ignored, not queued.
- Counter widths: $clog2(param+1) bits each; counters never wrap because the transitions fire at equality.

## Timing
- Reset values:
  - busy=0, dice_en=0, dice_err=0, dice_value=0 (0 means "no result yet").
  - State IDLE; synchronizer, edge register and all counters 0.
- roll_req at edge N → busy=1 after edge N+1.
- tick is asserted 3 clk edges after a cam_vsync falling edge (2 sync + 1 edge detect). A vsync glitch shorter than one clk may be missed; no requirement applies to it.
- Minimum roll latency: SETTLE_FRAMES + STABLE_FRAMES ticks, plus 1 clk to DONE.
- Maximum roll latency: SETTLE_FRAMES + TIMEOUT_FRAMES ticks, plus 1 clk to ERR.
- dice_value updates on the same edge DONE is entered, so it is valid in the dice_en cycle and after.
- busy deasserts on the edge after the DONE or ERR cycle.
- A tick arriving during DONE or ERR is discarded.
- Asynchronous reset mid-roll: outputs return to reset values immediately; no dice_en or dice_err pulse is produced.

## Test plan
Parameters for all scenarios: SETTLE_FRAMES=2, STABLE_FRAMES=3, TIMEOUT_FRAMES=10.
- Clean roll: init_done=1; roll_req pulse; dice_raw=4 on every frame → dice_en one cycle after the 5th tick following the request, dice_value=4, busy low one cycle later.
- Unstable then stable: dice_raw on sampling ticks 4,4,5,5,5 → dice_en on the 5th sampling tick +1, dice_value=5.
- Invalid frames: dice_raw 3,0,3,3,7,3,3,3 → the 0 and 7 frames reset the run; dice_en at the 8th sampling tick, dice_value=3.
- Timeout: dice_raw alternates 2,6 → dice_err one pulse after the 10th sampling tick; dice_value keeps its prior value; dice_en never asserts.
- Gating and overlap:
  - roll_req with init_done=0 → busy stays 0.
  - Second roll_req during SAMPLE → ignored; exactly one dice_en.
  - init_done dropped in SAMPLE → dice_err pulse, then IDLE.
- Reset mid-roll: assert reset during SAMPLE → busy=0, dice_value=0 immediately, no pulses; a new roll afterwards completes normally.
